// File: rtl/apb_cmd_master_if.sv
// Bus bundle for apb_cmd_master: command/response handshake plus the APB master signals.
// The master modport is the DUT's view and the slave modport is the surrounding environment's view.
interface apb_cmd_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, PRDATA, PREADY, PSLVERR,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, PSEL, PENABLE, PWRITE, PADDR, PWDATA
  );
endinterface

// File: rtl/apb_cmd_master.sv
// Command-driven APB master: FIFO-buffered write/read commands run as SETUP/ACCESS transfers,
// one response per command. Define APB_TIMEOUT_EN to abort transfers stalled in ACCESS.
module apb_cmd_master #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input logic             PCLK,
  input logic             PRESETn,
  apb_cmd_master_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 2) begin : g_bad_param
    $error("apb_cmd_master: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 2");
  end

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } cmd_t;

  logic [1:0]        rst_sync_q, rst_sync_d;
  logic              rst_n;
  state_t            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  cmd_t              fifo_q [FIFO_DEPTH];
  cmd_t              fifo_d [FIFO_DEPTH];
  cmd_t              head;
  logic              psel_q, psel_d, penable_q, penable_d, pwrite_q, pwrite_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              cmd_ready, push, pop;
`ifdef APB_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
`endif

  // Reset asserts immediately but is released only on a clock edge, two flops later.
  always_comb rst_sync_d = {rst_sync_q[0], 1'b1};

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) rst_sync_q <= '0;
    else          rst_sync_q <= rst_sync_d;
  end

  assign rst_n     = rst_sync_q[1];
  assign cmd_ready = (count_q != CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    fifo_d      = fifo_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
    wait_cnt_d  = wait_cnt_q;
`endif
    push = bus.cmd_valid && cmd_ready;
    pop  = 1'b0;
    head = fifo_q[rd_ptr_q];

    case (state_q)
      IDLE: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = head.write;
          paddr_d   = head.addr;
          pwdata_d  = head.wdata;
          state_d   = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        state_d   = ACCESS;
`ifdef APB_TIMEOUT_EN
        wait_cnt_d = '0;
`endif
      end
      ACCESS: begin
        if (bus.PREADY) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = pwrite_q ? '0 : bus.PRDATA;
          rsp_err_d   = bus.PSLVERR;
          state_d     = IDLE;
        end
`ifdef APB_TIMEOUT_EN
        // A PREADY on the last permitted ACCESS cycle takes the branch above, so it still wins.
        else if (wait_cnt_q == WAIT_W'(TIMEOUT - 1)) begin
          psel_d      = 1'b0;
          penable_d   = 1'b0;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          state_d     = IDLE;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase

    if (push) begin
      fifo_d[wr_ptr_q].write = bus.cmd_write;
      fifo_d[wr_ptr_q].addr  = bus.cmd_addr;
      fifo_d[wr_ptr_q].wdata = bus.cmd_wdata;
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO storage needs no reset: the flushed pointers and count make stale entries unreachable.
  always_ff @(posedge PCLK) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge PCLK or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= '0;
`endif
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
`ifdef APB_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
`endif
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.PSEL      = psel_q;
  assign bus.PENABLE   = penable_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PADDR     = paddr_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule

// File: tb/tb_apb_cmd_master.sv
// Testbench for apb_cmd_master: directed command table against a small APB slave model,
// plus hand-written sequences for FIFO-full, reset abort and (with APB_TIMEOUT_EN) timeout.
module tb_apb_cmd_master;
  logic PCLK = 1'b0;
  logic PRESETn = 1'b0;
  always #5 PCLK = ~PCLK;

  apb_cmd_master_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  apb_cmd_master #(.ADDR_W(32), .DATA_W(32), .FIFO_DEPTH(4), .TIMEOUT(16)) dut (
    .PCLK(PCLK),
    .PRESETn(PRESETn),
    .bus(bus)
  );

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    bit          slv_err;
    logic [31:0] exp_rdata;
    bit          exp_err;
    int          exp_lat;
  } vec_t;

  typedef struct {
    int waits;
    bit err;
  } plan_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          at;
  } rsp_t;

  int          tests_run = 0;
  int          tests_failed = 0;
  int          cyc = 0;
  vec_t        vecs [8];
  plan_t       plan_q [$];
  rsp_t        rsp_q [$];
  plan_t       cur;
  logic [31:0] mem [16];
  int          wcnt = 0;
  int          setup_cnt = 0;
  int          hold_err = 0;
  logic [31:0] cap_addr, cap_wdata;
  logic        cap_write;

  always @(posedge PCLK) cyc++;

  // Response monitor: every rsp_valid pulse is logged with the cycle it was seen in.
  always @(negedge PCLK) begin
    if (bus.rsp_valid) rsp_q.push_back('{bus.rsp_rdata, bus.rsp_err, cyc});
  end

  // APB slave model: per-transfer wait states and error from plan_q, 16-word memory.
  always @(negedge PCLK) begin
    if (!PRESETn) begin
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = 32'h0; wcnt = 0;
    end else if (bus.PSEL && !bus.PENABLE) begin
      setup_cnt++;
      hold_err = 0;
      cap_addr = bus.PADDR; cap_write = bus.PWRITE; cap_wdata = bus.PWDATA;
      wcnt = 0;
      if (plan_q.size() > 0) cur = plan_q.pop_front();
      else cur = '{0, 1'b0};
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    end else if (bus.PSEL && bus.PENABLE) begin
      if (bus.PADDR !== cap_addr || bus.PWRITE !== cap_write || bus.PWDATA !== cap_wdata) hold_err++;
      if (wcnt == cur.waits) begin
        bus.PREADY  = 1'b1;
        bus.PSLVERR = cur.err;
        bus.PRDATA  = bus.PWRITE ? 32'hDEADBEEF : mem[bus.PADDR[5:2]];
        if (bus.PWRITE && !cur.err) mem[bus.PADDR[5:2]] = bus.PWDATA;
      end else begin
        bus.PREADY = 1'b0; bus.PSLVERR = 1'b0; bus.PRDATA = 32'hDEADBEEF;
      end
      wcnt++;
    end else begin
      bus.PREADY = 1'b0; bus.PSLVERR = 1'b0;
    end
  end

  task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic checkResetState(input string tag);
    checkValue({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 32'h1);
    checkValue({tag, "_psel"},      32'(bus.PSEL),      32'h0);
    checkValue({tag, "_penable"},   32'(bus.PENABLE),   32'h0);
    checkValue({tag, "_pwrite"},    32'(bus.PWRITE),    32'h0);
    checkValue({tag, "_paddr"},     bus.PADDR,          32'h0);
    checkValue({tag, "_pwdata"},    bus.PWDATA,         32'h0);
    checkValue({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'h0);
    checkValue({tag, "_rsp_rdata"}, bus.rsp_rdata,      32'h0);
    checkValue({tag, "_rsp_err"},   32'(bus.rsp_err),   32'h0);
  endtask

  // Called at a negedge; leaves cmd_valid high so consecutive calls stream back-to-back.
  task automatic pushCmd(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int waits, input bit err, output int t0);
    bit rdy;
    int guard = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = wr; bus.cmd_addr = addr; bus.cmd_wdata = wdata;
    plan_q.push_back('{waits, err});
    do begin
      rdy = bus.cmd_ready;
      @(posedge PCLK);
      @(negedge PCLK);
      guard++;
    end while (!rdy && guard < 200);
    checkValue("cmd_accept", 32'(rdy), 32'h1);
    t0 = cyc;
  endtask

  task automatic waitRsp(output rsp_t r, output bit ok);
    int n = 0;
    #1;
    while (rsp_q.size() == 0 && n < 300) begin
      @(negedge PCLK);
      #1;
      n++;
    end
    ok = (rsp_q.size() != 0);
    if (ok) r = rsp_q.pop_front();
    else r = '{32'h0, 1'b0, 0};
  endtask

  task automatic applyStimulus(input vec_t v, output int t0);
    setup_cnt = 0;
    pushCmd(v.wr, v.addr, v.wdata, v.waits, v.slv_err, t0);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic checkOutput(input vec_t v, input int t0, input string tag);
    rsp_t r;
    bit   ok;
    waitRsp(r, ok);
    checkValue({tag, "_rsp_seen"}, 32'(ok), 32'h1);
    if (ok) begin
      checkValue({tag, "_rdata"},   r.rdata,      v.exp_rdata);
      checkValue({tag, "_err"},     32'(r.err),   32'(v.exp_err));
      checkValue({tag, "_latency"}, r.at - t0,    v.exp_lat);
    end
    checkValue({tag, "_setup_cycles"}, setup_cnt,      32'h1);
    checkValue({tag, "_paddr"},        cap_addr,       v.addr);
    checkValue({tag, "_pwrite"},       32'(cap_write), 32'(v.wr));
    if (v.wr) checkValue({tag, "_pwdata"}, cap_wdata, v.wdata);
    checkValue({tag, "_apb_stable"}, hold_err, 32'h0);
    @(negedge PCLK);
    checkValue({tag, "_pulse"},      32'(bus.rsp_valid), 32'h0);
    checkValue({tag, "_rdata_hold"}, bus.rsp_rdata,      v.exp_rdata);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int   t0, tb;
    int   n;
    rsp_t r;
    rsp_t rs [6];
    bit   ok;
    vec_t v;
    logic [31:0] exp_b2b [6];

    for (int i = 0; i < 16; i++) mem[i] = 32'(i) * 32'h11111111;
    bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_wdata = 32'h0;

    //         wr    addr         wdata         waits err  exp_rdata     exp_err lat
    vecs[0] = '{1'b1, 32'h1000, 32'hABCD1234, 0, 1'b0, 32'h00000000, 1'b0, 3};
    vecs[1] = '{1'b0, 32'h1000, 32'h00000000, 1, 1'b0, 32'hABCD1234, 1'b0, 4};
    vecs[2] = '{1'b1, 32'h1004, 32'h5A5A0001, 2, 1'b0, 32'h00000000, 1'b0, 5};
    vecs[3] = '{1'b0, 32'h1004, 32'h00000000, 0, 1'b0, 32'h5A5A0001, 1'b0, 3};
    vecs[4] = '{1'b0, 32'h1000, 32'h00000000, 0, 1'b1, 32'hABCD1234, 1'b1, 3};
    vecs[5] = '{1'b1, 32'h1008, 32'hFFFFFFFF, 0, 1'b1, 32'h00000000, 1'b1, 3};
    vecs[6] = '{1'b0, 32'h1008, 32'h00000000, 3, 1'b0, 32'h22222222, 1'b0, 6};
    vecs[7] = '{1'b0, 32'h100C, 32'h00000000, 0, 1'b0, 32'h33333333, 1'b0, 3};

    repeat (3) @(negedge PCLK);
    checkResetState("reset");
    PRESETn = 1'b1;
    repeat (4) @(negedge PCLK);
    checkResetState("post_release");

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], t0);
      checkOutput(vecs[i], t0, $sformatf("v%0d", i));
    end
    checkValue("idle_hold_paddr", bus.PADDR, 32'h100C);
    checkValue("idle_psel", 32'(bus.PSEL), 32'h0);

    // Stalled transfer keeps the FSM busy so four back-to-back pushes fill the FIFO.
    exp_b2b = '{32'h0, 32'h0, 32'h0, 32'h0, 32'h11, 32'h22};
    exp_b2b[5] = 32'h0;
    exp_b2b[3] = 32'h11;
    exp_b2b[4] = 32'h22;
    pushCmd(1'b1, 32'h1020, 32'hB10C0000, 10, 1'b0, t0);
    pushCmd(1'b1, 32'h1010, 32'h00000011, 0, 1'b0, tb);
    pushCmd(1'b1, 32'h1014, 32'h00000022, 0, 1'b0, tb);
    pushCmd(1'b0, 32'h1010, 32'h00000000, 0, 1'b0, tb);
    pushCmd(1'b0, 32'h1014, 32'h00000000, 0, 1'b0, tb);
    checkValue("full_after_4th_push", 32'(bus.cmd_ready), 32'h0);
    pushCmd(1'b1, 32'h1018, 32'h00000033, 0, 1'b0, tb);
    bus.cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      waitRsp(rs[i], ok);
      checkValue($sformatf("b2b%0d_seen", i), 32'(ok), 32'h1);
      checkValue($sformatf("b2b%0d_rdata", i), rs[i].rdata, exp_b2b[i]);
      checkValue($sformatf("b2b%0d_err", i), 32'(rs[i].err), 32'h0);
      if (i > 0) checkValue($sformatf("b2b%0d_spacing", i), rs[i].at - rs[i-1].at, 32'd3);
    end
    checkValue("b2b_mem_last_write", mem[6], 32'h00000033);

    // Reset during ACCESS with two commands still queued.
    pushCmd(1'b0, 32'h1000, 32'h0, 50, 1'b0, t0);
    pushCmd(1'b1, 32'h1030, 32'hBAD0BAD0, 0, 1'b0, tb);
    pushCmd(1'b1, 32'h1034, 32'hBAD0BAD1, 0, 1'b0, tb);
    bus.cmd_valid = 1'b0;
    n = 0;
    while (!(bus.PSEL && bus.PENABLE) && n < 20) begin
      @(negedge PCLK);
      n++;
    end
    checkValue("reached_access", 32'(bus.PSEL && bus.PENABLE), 32'h1);
    repeat (2) @(negedge PCLK);
    #2 PRESETn = 1'b0;
    #1 checkResetState("async_rst");
    plan_q.delete();
    rsp_q.delete();
    @(negedge PCLK);
    @(negedge PCLK);
    PRESETn = 1'b1;
    setup_cnt = 0;
    repeat (20) @(negedge PCLK);
    checkValue("no_rsp_after_rst", rsp_q.size(), 32'h0);
    checkValue("no_xfer_after_rst", setup_cnt, 32'h0);
    checkValue("ready_after_rst", 32'(bus.cmd_ready), 32'h1);
    v = '{1'b0, 32'h1030, 32'h0, 0, 1'b0, 32'hCCCCCCCC, 1'b0, 3};
    applyStimulus(v, t0);
    checkOutput(v, t0, "recover");

`ifdef APB_TIMEOUT_EN
    v = '{1'b0, 32'h1000, 32'h0, 100, 1'b0, 32'h00000000, 1'b1, 18};
    applyStimulus(v, t0);
    checkOutput(v, t0, "timeout");
    v = '{1'b0, 32'h1004, 32'h0, 15, 1'b0, 32'h5A5A0001, 1'b0, 18};
    applyStimulus(v, t0);
    checkOutput(v, t0, "ready_on_last");
    v = '{1'b1, 32'h1008, 32'h01020304, 0, 1'b0, 32'h00000000, 1'b0, 3};
    applyStimulus(v, t0);
    checkOutput(v, t0, "after_timeout");
`endif

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
